// File: rtl/cpu_pkg.sv
// Shared definitions for the mini CPU: FSM states, opcode fields and flag bit positions.
package cpu_pkg;

   typedef enum logic [2:0] {
      S_IDLE,
      S_FETCH,
      S_DECODE,
      S_EXEC,
      S_MEM,
      S_HALT
   } cpu_state_t;

   // Compute-class ops (instruction bit 7 set)
   localparam logic [2:0] OP_ADD  = 3'b000;
   localparam logic [2:0] OP_SHL  = 3'b001;
   localparam logic [2:0] OP_SHR  = 3'b010;
   localparam logic [2:0] OP_NOT  = 3'b011;
   localparam logic [2:0] OP_AND  = 3'b100;
   localparam logic [2:0] OP_OR   = 3'b101;
   localparam logic [2:0] OP_XOR  = 3'b110;
   localparam logic [2:0] OP_DISP = 3'b111;

   // Non-compute ops (instruction bit 7 clear)
   localparam logic [2:0] OP_LOAD  = 3'b000;
   localparam logic [2:0] OP_STORE = 3'b001;
   localparam logic [2:0] OP_DATA  = 3'b010;
   localparam logic [2:0] OP_JMPR  = 3'b011;
   localparam logic [2:0] OP_JMP   = 3'b100;
   localparam logic [2:0] OP_JCON  = 3'b101;
   localparam logic [2:0] OP_CLF   = 3'b110;
   localparam logic [2:0] OP_DISPA = 3'b111;

   // Positions inside the 4-bit flags vector {carry, greater, equal, zero}
   localparam int FLAG_ZERO    = 0;
   localparam int FLAG_EQUAL   = 1;
   localparam int FLAG_GREATER = 2;
   localparam int FLAG_CARRY   = 3;

   // A conditional jump is taken when any flag selected by the mask is set
   function automatic logic jcon_taken(input logic [3:0] mask, input logic [3:0] flags);
      return |(mask & flags);
   endfunction

endpackage

// File: rtl/cpu_alu.sv
// Combinational ALU: computes the result of a compute-class op plus all candidate flags.
// The core decides which flags actually get latched for a given op.
module cpu_alu
   import cpu_pkg::*;
#(
   parameter int DATA_W = 8
) (
   input  logic [DATA_W-1:0] a,
   input  logic [DATA_W-1:0] b,
   input  logic              cin,
   input  logic [2:0]        op,
   output logic [DATA_W-1:0] result,
   output logic              carry,
   output logic              greater,
   output logic              equal,
   output logic              zero
);

   logic [DATA_W:0] sum;

   assign sum     = {1'b0, a} + {1'b0, b} + {{DATA_W{1'b0}}, cin};
   assign greater = (a > b);
   assign equal   = (a == b);
   assign zero    = (result == '0);

   // Select the op result and the bit shifted or carried out of it
   always_comb begin
      result = '0;
      carry  = 1'b0;
      case (op)
         OP_ADD: begin
            result = sum[DATA_W-1:0];
            carry  = sum[DATA_W];
         end
         OP_SHL: begin
            result = {b[DATA_W-2:0], 1'b0};
            carry  = b[DATA_W-1];
         end
         OP_SHR: begin
            result = {1'b0, b[DATA_W-1:1]};
            carry  = b[0];
         end
         OP_NOT:  result = ~b;
         OP_AND:  result = a & b;
         OP_OR:   result = a | b;
         OP_XOR:  result = a ^ b;
         default: result = b;
      endcase
   end

endmodule

// File: rtl/mini_cpu_core.sv
// Mini CPU core: four registers, unified program/data memory with synchronous read,
// and a FETCH/DECODE/EXEC(/MEM) sequencer. Memory contents survive reset.
module mini_cpu_core
   import cpu_pkg::*;
#(
   parameter int DATA_W      = 8,
   parameter int ADDR_W      = 6,
   parameter int CARRY_CHAIN = 0
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   input  logic              prog_we,
   input  logic [ADDR_W-1:0] prog_addr,
   input  logic [DATA_W-1:0] prog_wdata,
   output logic [DATA_W-1:0] display,
   output logic              disp_valid,
   output logic              busy,
   output logic              halted,
   output logic [3:0]        flags
);

   localparam int DEPTH = 1 << ADDR_W;

   cpu_state_t        state;
   logic [ADDR_W-1:0] pc;
   logic [DATA_W-1:0] regs [4];
   logic [7:0]        ir;
   logic [DATA_W-1:0] mem [DEPTH];
   logic [DATA_W-1:0] mem_rdata;
   logic [DATA_W-1:0] result_q;
   logic              carry_f, greater_f, equal_f, zero_f;

   logic [ADDR_W-1:0] rd_addr;
   logic              mem_we;
   logic [ADDR_W-1:0] wr_addr;
   logic [DATA_W-1:0] wr_data;

   logic              ir_compute;
   logic [2:0]        ir_op;
   logic [1:0]        ir_ra, ir_rb;

   logic [DATA_W-1:0] alu_result;
   logic              alu_carry, alu_greater, alu_equal, alu_zero, alu_cin;

   assign ir_compute = ir[7];
   assign ir_op      = ir[6:4];
   assign ir_ra      = ir[3:2];
   assign ir_rb      = ir[1:0];

   assign flags  = {carry_f, greater_f, equal_f, zero_f};
   assign busy   = (state == S_FETCH) || (state == S_DECODE) ||
                   (state == S_EXEC)  || (state == S_MEM);
   assign halted = (state == S_HALT);
   assign alu_cin = (CARRY_CHAIN != 0) && carry_f;

   cpu_alu #(.DATA_W(DATA_W)) u_alu (
      .a       (regs[ir_ra]),
      .b       (regs[ir_rb]),
      .cin     (alu_cin),
      .op      (ir_op),
      .result  (alu_result),
      .carry   (alu_carry),
      .greater (alu_greater),
      .equal   (alu_equal),
      .zero    (alu_zero)
   );

   // During DECODE the fetched word is still in mem_rdata, so the operand read
   // (LOAD source or the word after the opcode) is launched straight from it.
   always_comb begin
      rd_addr = pc;
      if (state == S_DECODE) begin
         if (!mem_rdata[7] && (mem_rdata[6:4] == OP_LOAD))
            rd_addr = regs[mem_rdata[3:2]][ADDR_W-1:0];
         else
            rd_addr = pc + ADDR_W'(1);
      end
   end

   // Program loading is only accepted while idle or halted; STORE commits in MEM.
   // Reset suppresses any write so an aborted STORE leaves memory untouched.
   always_comb begin
      mem_we  = 1'b0;
      wr_addr = prog_addr;
      wr_data = prog_wdata;
      if (!rst) begin
         if (((state == S_IDLE) || (state == S_HALT)) && prog_we) begin
            mem_we = 1'b1;
         end else if ((state == S_MEM) && !ir_compute && (ir_op == OP_STORE)) begin
            mem_we  = 1'b1;
            wr_addr = regs[ir_ra][ADDR_W-1:0];
            wr_data = regs[ir_rb];
         end
      end
   end

   // Memory array with synchronous read; the read register holds its value
   // outside FETCH/DECODE so the operand is still there in MEM.
   always_ff @(posedge clk) begin
      if (mem_we)
         mem[wr_addr] <= wr_data;
      if ((state == S_FETCH) || (state == S_DECODE))
         mem_rdata <= mem[rd_addr];
   end

   // Instruction sequencer, register file, flags and display
   always_ff @(posedge clk) begin
      if (rst) begin
         state      <= S_IDLE;
         pc         <= '0;
         ir         <= '0;
         result_q   <= '0;
         display    <= '0;
         disp_valid <= 1'b0;
         carry_f    <= 1'b0;
         greater_f  <= 1'b0;
         equal_f    <= 1'b0;
         zero_f     <= 1'b0;
         for (int i = 0; i < 4; i++)
            regs[i] <= '0;
      end else begin
         disp_valid <= 1'b0;
         case (state)
            S_IDLE, S_HALT: begin
               if (start) begin
                  state <= S_FETCH;
                  pc    <= '0;
               end
            end
            S_FETCH: state <= S_DECODE;
            S_DECODE: begin
               ir    <= mem_rdata[7:0];
               state <= S_EXEC;
            end
            S_EXEC: begin
               state <= S_FETCH;
               if (ir_compute) begin
                  pc <= pc + ADDR_W'(1);
                  if (ir_op == OP_DISP) begin
                     display    <= regs[ir_rb];
                     disp_valid <= 1'b1;
                  end else begin
                     regs[ir_rb] <= alu_result;
                     result_q    <= alu_result;
                     zero_f      <= alu_zero;
                     if ((ir_op == OP_ADD) || (ir_op == OP_SHL) || (ir_op == OP_SHR))
                        carry_f <= alu_carry;
                     if (ir_op == OP_XOR) begin
                        greater_f <= alu_greater;
                        equal_f   <= alu_equal;
                     end
                  end
               end else begin
                  case (ir_op)
                     OP_LOAD, OP_STORE, OP_DATA, OP_JMP: state <= S_MEM;
                     OP_JMPR: pc <= regs[ir_rb][ADDR_W-1:0];
                     OP_JCON: begin
                        if (ir[3:0] == 4'b0000)
                           state <= S_HALT;
                        else if (jcon_taken(ir[3:0], flags))
                           state <= S_MEM;
                        else
                           pc <= pc + ADDR_W'(2);
                     end
                     OP_CLF: begin
                        carry_f   <= 1'b0;
                        greater_f <= 1'b0;
                        equal_f   <= 1'b0;
                        zero_f    <= 1'b0;
                        pc        <= pc + ADDR_W'(1);
                     end
                     default: begin
                        display    <= result_q;
                        disp_valid <= 1'b1;
                        pc         <= pc + ADDR_W'(1);
                     end
                  endcase
               end
            end
            S_MEM: begin
               state <= S_FETCH;
               case (ir_op)
                  OP_LOAD: begin
                     regs[ir_rb] <= mem_rdata;
                     pc          <= pc + ADDR_W'(1);
                  end
                  OP_STORE: pc <= pc + ADDR_W'(1);
                  OP_DATA: begin
                     regs[ir_rb] <= mem_rdata;
                     pc          <= pc + ADDR_W'(2);
                  end
                  default: pc <= mem_rdata[ADDR_W-1:0];
               endcase
            end
            default: state <= S_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_mini_cpu_core.sv
// Directed bench for mini_cpu_core: small hand-assembled programs are loaded through
// the program port, run to HALT, and the display stream and flags are compared.
module tb_mini_cpu_core;

   logic       clk = 1'b0;
   logic       rst;
   logic       start;
   logic       prog_we;
   logic [5:0] prog_addr;
   logic [7:0] prog_wdata;
   logic [7:0] display, cc_display;
   logic       disp_valid, cc_disp_valid;
   logic       busy, cc_busy;
   logic       halted, cc_halted;
   logic [3:0] flags, cc_flags;

   int compared   = 0;
   int mismatched = 0;

   typedef struct {
      logic [2:0] op;
      logic [7:0] a;
      logic [7:0] b;
      bit         use_dispa;
      logic [7:0] exp_disp;
      logic [3:0] exp_flags;
   } alu_vec_t;

   typedef struct {
      int         addr;
      logic [7:0] data;
   } prog_word_t;

   alu_vec_t   vecs [15];
   prog_word_t prog [$];
   logic [7:0] disp_q [$];
   logic [7:0] exp_q [$];
   int         double_pulses;
   bit         prev_valid = 1'b0;

   mini_cpu_core #(.DATA_W(8), .ADDR_W(6), .CARRY_CHAIN(0)) dut (
      .clk        (clk),
      .rst        (rst),
      .start      (start),
      .prog_we    (prog_we),
      .prog_addr  (prog_addr),
      .prog_wdata (prog_wdata),
      .display    (display),
      .disp_valid (disp_valid),
      .busy       (busy),
      .halted     (halted),
      .flags      (flags)
   );

   mini_cpu_core #(.DATA_W(8), .ADDR_W(6), .CARRY_CHAIN(1)) dut_cc (
      .clk        (clk),
      .rst        (rst),
      .start      (start),
      .prog_we    (prog_we),
      .prog_addr  (prog_addr),
      .prog_wdata (prog_wdata),
      .display    (cc_display),
      .disp_valid (cc_disp_valid),
      .busy       (cc_busy),
      .halted     (cc_halted),
      .flags      (cc_flags)
   );

   always #5 clk = ~clk;

   // Record every display pulse and flag any pulse that lasts longer than a cycle
   always @(negedge clk) begin
      if (disp_valid) begin
         disp_q.push_back(display);
         if (prev_valid)
            double_pulses++;
      end
      prev_valid = disp_valid;
   end

   // Hard stop in case something upstream never returns
   initial begin
      #1000000;
      $display("[TB] FAIL watchdog: simulation time limit reached");
      $fatal(1, "[TB] watchdog");
   end

   task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
      compared++;
      if (actual !== expected) begin
         mismatched++;
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
      end
   endtask

   task automatic addWord(input int addr, input logic [7:0] data);
      prog_word_t w;
      w.addr = addr;
      w.data = data;
      prog.push_back(w);
   endtask

   task automatic writeWord(input int addr, input logic [7:0] data, input bit with_start);
      @(negedge clk);
      prog_we    = 1'b1;
      prog_addr  = addr[5:0];
      prog_wdata = data;
      start      = with_start;
      @(posedge clk);
      #1;
      prog_we = 1'b0;
      start   = 1'b0;
   endtask

   // Entry 0 (address 0) is written last, in the same cycle as start
   task automatic loadAndStart();
      for (int i = prog.size() - 1; i >= 1; i--)
         writeWord(prog[i].addr, prog[i].data, 1'b0);
      writeWord(prog[0].addr, prog[0].data, 1'b1);
   endtask

   task automatic waitHalt(input string name, input int budget);
      int n = 0;
      while (!halted && n < budget) begin
         @(negedge clk);
         n++;
      end
      checkOutput({name, "_halted"}, {31'b0, halted}, 32'd1);
   endtask

   task automatic runProgram(input string name, input int budget, input bit busy_write);
      disp_q.delete();
      double_pulses = 0;
      loadAndStart();
      if (busy_write) begin
         for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            prog_we    = 1'b1;
            prog_addr  = 6'd40;
            prog_wdata = 8'hEE;
         end
         @(negedge clk);
         prog_we = 1'b0;
      end
      waitHalt(name, budget);
   endtask

   task automatic checkDisplays(input string name);
      checkOutput({name, "_count"}, disp_q.size(), exp_q.size());
      checkOutput({name, "_pulse"}, double_pulses, 0);
      for (int i = 0; i < exp_q.size(); i++)
         if (i < disp_q.size())
            checkOutput($sformatf("%s_disp%0d", name, i), {24'b0, disp_q[i]}, {24'b0, exp_q[i]});
   endtask

   task automatic doReset();
      @(negedge clk);
      rst     = 1'b1;
      start   = 1'b0;
      prog_we = 1'b0;
      @(posedge clk);
      @(negedge clk);
      rst = 1'b0;
   endtask

   // Each table row becomes: CLF; DATA R0,a; DATA R1,b; op R0,R1; DISP R1|DISPA; HALT
   task automatic applyStimulus();
      for (int i = 0; i < 15; i++) begin
         string nm;
         nm = $sformatf("vec%0d", i);
         prog.delete();
         addWord(0, 8'h60);
         addWord(1, 8'h20);
         addWord(2, vecs[i].a);
         addWord(3, 8'h21);
         addWord(4, vecs[i].b);
         addWord(5, {1'b1, vecs[i].op, 4'b0001});
         addWord(6, vecs[i].use_dispa ? 8'h70 : 8'hF1);
         addWord(7, 8'h50);
         runProgram(nm, 500, 1'b0);
         exp_q.delete();
         exp_q.push_back(vecs[i].exp_disp);
         checkDisplays(nm);
         checkOutput({nm, "_flags"}, {28'b0, flags}, {28'b0, vecs[i].exp_flags});
      end
   endtask

   initial begin
      rst        = 1'b1;
      start      = 1'b0;
      prog_we    = 1'b0;
      prog_addr  = '0;
      prog_wdata = '0;

      //          op      a      b     dispa  disp   {c,g,e,z}
      vecs[0]  = '{3'b000, 8'h05, 8'h07, 1'b0, 8'h0C, 4'b0000};
      vecs[1]  = '{3'b000, 8'hFF, 8'h01, 1'b0, 8'h00, 4'b1001};
      vecs[2]  = '{3'b001, 8'h00, 8'h81, 1'b0, 8'h02, 4'b1000};
      vecs[3]  = '{3'b010, 8'h00, 8'h81, 1'b0, 8'h40, 4'b1000};
      vecs[4]  = '{3'b010, 8'h00, 8'h01, 1'b0, 8'h00, 4'b1001};
      vecs[5]  = '{3'b011, 8'h00, 8'hFF, 1'b0, 8'h00, 4'b0001};
      vecs[6]  = '{3'b100, 8'hF0, 8'h3C, 1'b0, 8'h30, 4'b0000};
      vecs[7]  = '{3'b101, 8'h0F, 8'h30, 1'b0, 8'h3F, 4'b0000};
      vecs[8]  = '{3'b110, 8'h09, 8'h03, 1'b0, 8'h0A, 4'b0100};
      vecs[9]  = '{3'b110, 8'h05, 8'h05, 1'b0, 8'h00, 4'b0011};
      vecs[10] = '{3'b000, 8'h05, 8'h07, 1'b1, 8'h0C, 4'b0000};
      vecs[11] = '{3'b000, 8'h80, 8'h80, 1'b1, 8'h00, 4'b1001};
      vecs[12] = '{3'b001, 8'h00, 8'h40, 1'b0, 8'h80, 4'b0000};
      vecs[13] = '{3'b011, 8'h00, 8'h5A, 1'b0, 8'hA5, 4'b0000};
      vecs[14] = '{3'b110, 8'h03, 8'h09, 1'b0, 8'h0A, 4'b0000};

      repeat (2) @(posedge clk);
      @(negedge clk);
      rst = 1'b0;
      checkOutput("reset_display", {24'b0, display}, 32'h0);
      checkOutput("reset_busy",    {31'b0, busy},    32'h0);
      checkOutput("reset_halted",  {31'b0, halted},  32'h0);
      checkOutput("reset_flags",   {28'b0, flags},   32'h0);

      applyStimulus();

      // Carry chain: second ADD sees carry-in only in the CARRY_CHAIN=1 instance
      prog.delete();
      addWord(0, 8'h60); addWord(1, 8'h20); addWord(2, 8'hFF);
      addWord(3, 8'h21); addWord(4, 8'h01); addWord(5, 8'h81);
      addWord(6, 8'h81); addWord(7, 8'hF1); addWord(8, 8'h50);
      runProgram("carry", 500, 1'b0);
      checkOutput("carry_disp",     {24'b0, display},    32'hFF);
      checkOutput("carry_flags",    {28'b0, flags},      32'h0);
      checkOutput("carry_cc_halt",  {31'b0, cc_halted},  32'h1);
      checkOutput("carry_cc_disp",  {24'b0, cc_display}, 32'h00);
      checkOutput("carry_cc_flags", {28'b0, cc_flags},   32'h9);

      // JCON on equal: taken after 9^9, not taken after 3^9
      prog.delete();
      addWord(0, 8'h60);
      addWord(1, 8'h22);  addWord(2, 8'd9);
      addWord(3, 8'h23);  addWord(4, 8'd9);
      addWord(5, 8'hEB);  addWord(6, 8'h52);  addWord(7, 8'd20);
      addWord(8, 8'h20);  addWord(9, 8'hEE);  addWord(10, 8'hF0); addWord(11, 8'h50);
      addWord(20, 8'h20); addWord(21, 8'hA1); addWord(22, 8'hF0);
      addWord(23, 8'h22); addWord(24, 8'd3);
      addWord(25, 8'h23); addWord(26, 8'd9);
      addWord(27, 8'hEB); addWord(28, 8'h52); addWord(29, 8'd8);
      addWord(30, 8'h20); addWord(31, 8'hB2); addWord(32, 8'hF0); addWord(33, 8'h50);
      runProgram("jcon", 1000, 1'b0);
      exp_q = '{8'hA1, 8'hB2};
      checkDisplays("jcon");
      checkOutput("jcon_flags", {28'b0, flags}, 32'h0);

      // Fibonacci with STORE/LOAD shuffling and an equal-flag exit
      prog.delete();
      addWord(0, 8'h60);
      addWord(1, 8'h20);  addWord(2, 8'd0);
      addWord(3, 8'h21);  addWord(4, 8'd1);
      addWord(5, 8'hF0);
      addWord(6, 8'h22);  addWord(7, 8'd34);
      addWord(8, 8'hE2);
      addWord(9, 8'h52);  addWord(10, 8'd20);
      addWord(11, 8'h23); addWord(12, 8'd60);
      addWord(13, 8'h1D); addWord(14, 8'h81); addWord(15, 8'h0C);
      addWord(16, 8'h40); addWord(17, 8'd5);
      addWord(20, 8'h50);
      runProgram("fib", 3000, 1'b0);
      exp_q = '{8'd0, 8'd1, 8'd1, 8'd2, 8'd3, 8'd5, 8'd8, 8'd13, 8'd21, 8'd34};
      checkDisplays("fib");
      checkOutput("fib_flags", {28'b0, flags}, 32'h3);

      // STORE rewrites the very next instruction into DISP R1
      prog.delete();
      addWord(0, 8'h20); addWord(1, 8'd5);
      addWord(2, 8'h21); addWord(3, 8'hF1);
      addWord(4, 8'h11); addWord(5, 8'h50); addWord(6, 8'h50);
      runProgram("smc", 500, 1'b0);
      exp_q = '{8'hF1};
      checkDisplays("smc");

      // Reset during MEM of a STORE: target keeps its old value, outputs clear
      doReset();
      writeWord(40, 8'h33, 1'b0);
      prog.delete();
      addWord(0, 8'h20); addWord(1, 8'd40);
      addWord(2, 8'h21); addWord(3, 8'h77);
      addWord(4, 8'hF1); addWord(5, 8'h11); addWord(6, 8'h50);
      loadAndStart();
      repeat (14) @(posedge clk);
      @(negedge clk);
      checkOutput("rstmem_busy_before", {31'b0, busy},    32'h1);
      checkOutput("rstmem_disp_before", {24'b0, display}, 32'h77);
      rst = 1'b1;
      @(posedge clk);
      @(negedge clk);
      rst = 1'b0;
      checkOutput("rstmem_display", {24'b0, display},    32'h0);
      checkOutput("rstmem_valid",   {31'b0, disp_valid}, 32'h0);
      checkOutput("rstmem_busy",    {31'b0, busy},       32'h0);
      checkOutput("rstmem_halted",  {31'b0, halted},     32'h0);
      checkOutput("rstmem_flags",   {28'b0, flags},      32'h0);

      // Read back word 40 while prog_we hammers it during busy cycles
      prog.delete();
      addWord(0, 8'h20); addWord(1, 8'd40);
      addWord(2, 8'h01); addWord(3, 8'hF1); addWord(4, 8'h50);
      runProgram("memkeep", 500, 1'b1);
      exp_q = '{8'h33};
      checkDisplays("memkeep");

      // Jump to the last word; a one-word op there must wrap pc back to 0
      doReset();
      prog.delete();
      addWord(0, 8'h51);  addWord(1, 8'd10);
      addWord(2, 8'h40);  addWord(3, 8'd63);
      addWord(63, 8'hE0);
      addWord(10, 8'h21); addWord(11, 8'h5A); addWord(12, 8'hF1); addWord(13, 8'h50);
      runProgram("wrap", 500, 1'b0);
      exp_q = '{8'h5A};
      checkDisplays("wrap");
      checkOutput("wrap_flags", {28'b0, flags}, 32'h3);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule

// File: doc/mini_cpu_core.md
MINI_CPU_CORE -- requirements
Module: mini_cpu_core

Interface
REQ-001 Parameter DATA_W, 8, datapath/register/memory word width; legal range 8..32.
REQ-002 Parameter ADDR_W, 6, memory address width; depth 2**ADDR_W; ADDR_W <= DATA_W.
REQ-003 Parameter CARRY_CHAIN, 0, when 1 ADD includes carry flag as carry-in; when 0 carry-in is 0.
REQ-004 clk  in  1  processor clock; all state changes on posedge.
REQ-005 rst  in  1  synchronous, active-high reset.
REQ-006 start  in  1  begin execution at address 0; sampled only in IDLE or HALT.
REQ-007 prog_we  in  1  program-load write strobe; honoured only when busy=0.
REQ-008 prog_addr  in  ADDR_W  program-load address.
REQ-009 prog_wdata  in  DATA_W  program-load data.
REQ-010 display  out  DATA_W  last displayed value (registered).
REQ-011 disp_valid  out  1  one-cycle pulse when display updates.
REQ-012 busy  out  1  high in FETCH/DECODE/EXEC/MEM.
REQ-013 halted  out  1  high in HALT.
REQ-014 flags  out  4  {carry, greater, equal, zero}.

Function
REQ-015 Unified memory 2**ADDR_W x DATA_W shall hold program and data; opcode in bits [7:0] of a word: [7] compute, [6:4] op, [3:2] RA, [1:0] RB; four registers R0..R3, DATA_W wide.
REQ-016 FSM states IDLE, FETCH, DECODE, EXEC, MEM, HALT; IDLE/HALT -> FETCH on start (pc=0); FETCH -> DECODE -> EXEC; EXEC -> MEM for LOAD, STORE, DATA, JMP, taken JCON; else EXEC -> FETCH; MEM -> FETCH.
REQ-017 Memory read shall be synchronous (1-cycle latency); instruction execution takes 3 cycles, memory-class instructions 4.
REQ-018 Compute ops: 000 ADD RB=RA+RB(+cin), carry=bit DATA_W; 001 SHL RB={RB[W-2:0],0}, carry=old RB[W-1]; 010 SHR RB={0,RB[W-1:1]}, carry=old RB[0]; 011 NOT RB=~RB; 100 AND; 101 OR; 110 XOR RB=RA^RB with greater=(RA>RB), equal=(RA==RB) both re-evaluated every XOR (non-sticky); 111 DISP display=RB.
REQ-019 Every compute op except DISP shall set zero=(result==0); carry changes only on ADD/SHL/SHR; greater/equal change only on XOR; all arithmetic unsigned, modulo 2**DATA_W.
REQ-020 Non-compute ops: 000 LOAD RB=mem[RA]; 001 STORE mem[RA]=RB; 010 DATA RB=mem[pc+1], pc+=2; 011 JMPR pc=RB; 100 JMP pc=mem[pc+1]; 101 JCON mask=[3:0]; 110 CLF all flags=0; 111 DISPA display=last ALU result.
REQ-021 JCON with nonzero mask: if (mask & flags)!=0 then pc=mem[pc+1], else pc=pc+2; JCON with mask 0000 shall enter HALT.
REQ-022 Addresses taken from registers or memory shall use their low ADDR_W bits; pc increments wrap modulo 2**ADDR_W.
REQ-023 disp_valid shall pulse exactly one cycle, coincident with the display update, for DISP and DISPA.
REQ-024 prog_we while busy=1 shall be ignored; start while busy=1 shall be ignored.
REQ-025 prog_we and start in the same IDLE cycle: write completes, execution begins next cycle and observes the written word.
REQ-026 STORE to the address of the next instruction shall be visible to its fetch.

Reset
REQ-027 rst shall force state IDLE, pc=0, R0..R3=0, flags=0, result=0, display=0, disp_valid=0, busy=0, halted=0.
REQ-028 rst shall not clear memory; rst mid-instruction aborts it with no partial register or memory write.

Structure
REQ-029 Package cpu_pkg shall hold state enum, op-field constants, flag bit indices.
REQ-030 Combinational sub-module cpu_alu (a, b, cin, op -> result, carry, greater, equal, zero) shall be instantiated once.

Verification
REQ-031 Load DATA R0,5; DATA R1,7; ADD; DISP R1 -> display=12, disp_valid single pulse, flags zero=0 carry=0.
REQ-032 DATA_W=8: R0=0xFF, R1=0x01, ADD -> R1=0x00, carry=1, zero=1; CARRY_CHAIN=1 second ADD R0,R1 -> R1=0x00, carry=1.
REQ-033 XOR R2,R3 with R2=R3=9 then JCON 0010 -> jump taken; then R2=3,R3=9 XOR, JCON 0010 -> pc=pc+2 (equal cleared).
REQ-034 Fibonacci program (store loop to memory, JCON equal exit, JCON 0000) -> displays 0,1,1,2,3,5,8,13,21,34; halted=1.
REQ-035 rst asserted during MEM of STORE -> target word unchanged, all outputs at reset values next cycle.
REQ-036 prog_we asserted while busy=1 -> memory unchanged; JMP to 2**ADDR_W-1 followed by single-word op -> pc wraps to 0.
